// File: rtl/regfile_wb_queue_if.sv
// ============================================================================
//  regfile_wb_queue_if : writeback queue handshake, drain port and bypass bus
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic [63:0]      in_data;
  logic             drain_en;
  logic             RegWrite;
  logic [4:0]       RD;
  logic [63:0]      WriteData;
  logic [4:0]       RS1;
  logic [4:0]       RS2;
  logic             byp1_hit;
  logic             byp2_hit;
  logic [63:0]      byp1_data;
  logic [63:0]      byp2_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  modport slave (
    input  in_valid, in_rd, in_data, drain_en, RS1, RS2,
    output in_ready, RegWrite, RD, WriteData,
           byp1_hit, byp2_hit, byp1_data, byp2_data, count, empty, full
  );

  modport master (
    output in_valid, in_rd, in_data, drain_en, RS1, RS2,
    input  in_ready, RegWrite, RD, WriteData,
           byp1_hit, byp2_hit, byp1_data, byp2_data, count, empty, full
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_queue.sv
// ============================================================================
//  regfile_wb_queue : in-order writeback queue in front of the regfile write
//  port, with optional youngest-match bypass (macro WB_QUEUE_BYPASS_EN).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb_queue #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  regfile_wb_queue_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       r_rd   [DEPTH];
  logic [63:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty, w_full, w_accept, w_push, w_pop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  // A full queue refuses input even when it pops this cycle.
  assign w_accept = bus.in_valid && !w_full && !reset;
  assign w_push   = w_accept && (bus.in_rd != 5'd0);
  assign w_pop    = !w_empty && bus.drain_en && !reset;

  assign bus.in_ready  = !w_full && !reset;
  assign bus.RegWrite  = w_pop;
  assign bus.RD        = w_empty ? 5'd0  : r_rd[r_rptr];
  assign bus.WriteData = w_empty ? 64'd0 : r_data[r_rptr];
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: validity is defined by the count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= bus.in_rd;
      r_data[r_wptr] <= bus.in_data;
    end
  end

`ifdef WB_QUEUE_BYPASS_EN
  logic        w_hit1, w_hit2;
  logic [63:0] w_bdata1, w_bdata2;

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    w_hit1   = 1'b0;
    w_hit2   = 1'b0;
    w_bdata1 = 64'd0;
    w_bdata2 = 64'd0;
    w_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if ((bus.RS1 != 5'd0) && (r_rd[w_idx] == bus.RS1)) begin
          w_hit1   = 1'b1;
          w_bdata1 = r_data[w_idx];
        end
        if ((bus.RS2 != 5'd0) && (r_rd[w_idx] == bus.RS2)) begin
          w_hit2   = 1'b1;
          w_bdata2 = r_data[w_idx];
        end
      end
    end
  end

  assign bus.byp1_hit  = w_hit1;
  assign bus.byp2_hit  = w_hit2;
  assign bus.byp1_data = w_bdata1;
  assign bus.byp2_data = w_bdata2;
`else
  assign bus.byp1_hit  = 1'b0;
  assign bus.byp2_hit  = 1'b0;
  assign bus.byp1_data = 64'd0;
  assign bus.byp2_data = 64'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
// ============================================================================
//  tb_regfile_wb_queue : directed + random checks against a queue model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_queue_if #(.DEPTH(DEPTH)) bus ();

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // Reference: pending writes, oldest at index 0.
  logic [4:0]  q_rd   [$];
  logic [63:0] q_data [$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [63:0] d, input logic drn);
    bus.in_valid = v;
    bus.in_rd    = rd;
    bus.in_data  = d;
    bus.drain_en = drn;
    #1;
  endtask

  task automatic model_byp(input logic [4:0] rs, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = 64'd0;
`ifdef WB_QUEUE_BYPASS_EN
    if (rs != 5'd0)
      foreach (q_rd[i])
        if (q_rd[i] == rs) begin
          hit = 1'b1;
          d   = q_data[i];
        end
`endif
  endtask

  // Compare every output with the model, then advance one clock.
  task automatic tick();
    logic        h;
    logic [63:0] d;
    int          sz;
    logic        pop;
    logic        acc;
    #1;
    sz = q_rd.size();
    chk("in_ready", 64'(bus.in_ready), 64'(!reset && sz < DEPTH));
    chk("RegWrite", 64'(bus.RegWrite), 64'(!reset && bus.drain_en && sz > 0));
    chk("RD",        64'(bus.RD),       sz > 0 ? 64'(q_rd[0]) : 64'd0);
    chk("WriteData", bus.WriteData,     sz > 0 ? q_data[0]    : 64'd0);
    chk("count", 64'(bus.count), 64'(sz));
    chk("empty", 64'(bus.empty), 64'(sz == 0));
    chk("full",  64'(bus.full),  64'(sz == DEPTH));
    model_byp(bus.RS1, h, d);
    chk("byp1_hit", 64'(bus.byp1_hit), 64'(h));
    chk("byp1_data", bus.byp1_data, d);
    model_byp(bus.RS2, h, d);
    chk("byp2_hit", 64'(bus.byp2_hit), 64'(h));
    chk("byp2_data", bus.byp2_data, d);
    @(posedge clk);
    if (reset) begin
      q_rd.delete();
      q_data.delete();
    end else begin
      pop = bus.drain_en && sz > 0;
      acc = bus.in_valid && sz < DEPTH;
      if (pop) begin
        void'(q_rd.pop_front());
        void'(q_data.pop_front());
      end
      if (acc && bus.in_rd != 5'd0) begin
        q_rd.push_back(bus.in_rd);
        q_data.push_back(bus.in_data);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    bus.RS1 = 5'd0;
    bus.RS2 = 5'd0;
    drive(1'b0, 5'd0, 64'd0, 1'b1);
    tick();
    chk("RegWrite_in_reset", 64'(bus.RegWrite), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(bus.in_ready), 64'd1);
    chk("empty_after_reset", 64'(bus.empty), 64'd1);

    // single push drained in the following cycle
    drive(1'b1, 5'd5, 64'hAAAA, 1'b1);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1);
    chk("t1_RegWrite", 64'(bus.RegWrite), 64'd1);
    chk("t1_RD", 64'(bus.RD), 64'd5);
    chk("t1_WriteData", bus.WriteData, 64'hAAAA);
    tick();
    chk("t1_empty", 64'(bus.empty), 64'd1);

    // fill to full, hold a fifth push, then drain in order
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(k), 64'(k * 'h11), 1'b0);
      tick();
    end
    drive(1'b1, 5'd9, 64'h99, 1'b0);
    chk("t2_full", 64'(bus.full), 64'd1);
    chk("t2_ready", 64'(bus.in_ready), 64'd0);
    chk("t2_count", 64'(bus.count), 64'd4);
    tick();
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("t2_RegWrite", 64'(bus.RegWrite), 64'd1);
      chk("t2_RD_order", 64'(bus.RD), 64'(k));
      chk("t2_data_order", bus.WriteData, 64'(k * 'h11));
      tick();
    end
    chk("t2_empty", 64'(bus.empty), 64'd1);

    // x0 write is accepted but discarded
    drive(1'b1, 5'd0, 64'hFFFF, 1'b1);
    chk("t3_ready", 64'(bus.in_ready), 64'd1);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1);
    chk("t3_count", 64'(bus.count), 64'd0);
    chk("t3_RegWrite", 64'(bus.RegWrite), 64'd0);

    // bypass youngest match
    drive(1'b1, 5'd7, 64'h1, 1'b0); tick();
    drive(1'b1, 5'd7, 64'h2, 1'b0); tick();
    drive(1'b1, 5'd3, 64'h9, 1'b0); tick();
    bus.RS1 = 5'd7;
    bus.RS2 = 5'd3;
    drive(1'b0, 5'd0, 64'd0, 1'b0);
`ifdef WB_QUEUE_BYPASS_EN
    chk("t4_hit1", 64'(bus.byp1_hit), 64'd1);
    chk("t4_data1", bus.byp1_data, 64'h2);
    chk("t4_hit2", 64'(bus.byp2_hit), 64'd1);
    chk("t4_data2", bus.byp2_data, 64'h9);
`else
    chk("t4_hit1_off", 64'(bus.byp1_hit), 64'd0);
    chk("t4_data2_off", bus.byp2_data, 64'd0);
`endif
    bus.RS1 = 5'd0;
    #1;
    chk("t4_rs0_nohit", 64'(bus.byp1_hit), 64'd0);
    tick();

    // half full with simultaneous push and drain, pointers wrap
    drive(1'b0, 5'd0, 64'd0, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(10 + i), 64'(i + 'h100), 1'b1);
      chk("t5_count_const", 64'(bus.count), 64'd2);
      tick();
    end

    // reset with pending entries
    drive(1'b1, 5'd20, 64'h20, 1'b0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_pending", 64'(bus.count), 64'd3);
    chk("t6_RegWrite_reset", 64'(bus.RegWrite), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_empty", 64'(bus.empty), 64'd1);
    chk("t6_no_write", 64'(bus.RegWrite), 64'd0);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 49) == 0);
      bus.RS1 = 5'($urandom_range(0, 7));
      bus.RS2 = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
